alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin controller that lets two requesters share the single registered ALU (4-bit operands, 2-bit opcode, 8-bit result). It captures one requester's operands and drives the ALU inputs. It waits out the ALU latency, then captures alu_out and returns it to the winning requester with a one-cycle done pulse. It sits between the requester blocks and the ALU; the ALU's own reset is driven elsewhere.

Parameters:
ALU_LAT, 1, rising edges from the ALU sampling alu_a/alu_b/alu_op to a valid alu_out (legal range 1..7).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request, held until gnt0
a0  input  4  requester 0 operand A
b0  input  4  requester 0 operand B
op0  input  2  requester 0 opcode (0 add, 1 or, 2 sub, 3 xor)
req1  input  1  requester 1 request
a1  input  4  requester 1 operand A
b1  input  4  requester 1 operand B
op1  input  2  requester 1 opcode
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
done0  output  1  one-cycle pulse: result valid for requester 0
done1  output  1  one-cycle pulse: result valid for requester 1
result  output  8  last captured ALU result, held until next capture
busy  output  1  high while in EXEC
alu_a  output  4  ALU operand A (registered)
alu_b  output  4  ALU operand B (registered)
alu_op  output  2  ALU opcode (registered)
alu_out  input  8  ALU result

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the latency counter to 0.
  - The priority pointer goes to requester 0.
  - gnt0, gnt1, done0, done1, busy go to 0; result, alu_a, alu_b, alu_op go to 0.
  - Reset during EXEC drops the operation: no done is issued, and the requester must re-request.
- All outputs are registered. FSM states are IDLE and EXEC.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
- On the grant edge:
  - Load alu_a/alu_b/alu_op from the winner's inputs.
  - Assert gnt_x for exactly one cycle.
  - Load the counter with ALU_LAT, set busy=1, go to EXEC.
  - Record the winner, and point the priority pointer at the other requester.
- EXEC:
  - The counter decrements on every edge.
  - On the edge where the counter equals 1, capture alu_out into result, assert done_x (winner only) for exactly one cycle, clear busy, and return to IDLE.
  - Requests are ignored in EXEC; alu_a/alu_b/alu_op stay stable for the whole operation.
- Timing:
  - Grant edge = edge G; result/done appear after edge G+ALU_LAT.
  - The earliest next grant edge is G+ALU_LAT+1, so one operation completes every ALU_LAT+1 cycles under continuous requests.
- Handshake:
  - A requester holds req and operands stable until it sees gnt.
  - It may deassert req in the cycle after gnt.
  - req still high after gnt counts as a new request; with the other requester idle, it is granted again at the next IDLE.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1,...; neither requester waits for more than one foreign operation.
- gnt0/gnt1 are never high together, and done0/done1 are never high together.
- result is not modified except on a capture edge.
- Width rules: the arbiter passes alu_out through unmodified. The bench ALU model zero-extends operands to 8 bits and wraps modulo 256.

Test Plan:
1. Reset: hold rst=0 with req0=1 for 3 cycles, then release -> all outputs 0 throughout; first grant is gnt0 on the edge after release.
2. Single op, ALU_LAT=1: req0 with a0=5, b0=5, op0=0 -> gnt0 pulse one cycle, alu_a=5; done0 pulse one edge later with result=10; busy high for exactly 1 cycle.
3. Simultaneous: req0 (9 add 8) and req1 (3 sub 5) asserted together and held -> gnt0 first, done0 with result=17; then gnt1, done1 with result=254; then gnt0 again.
4. Latency param, ALU_LAT=3: req1 with a1=12, b1=10, op1=3 -> done1 exactly 3 edges after gnt1, result=6; a req0 arriving mid-operation is granted only after done1.
5. Reset mid-op: assert rst=0 one cycle after gnt0 -> no done0; result=0; after release with req0 still high -> new gnt0 issued.
6. Back-to-back single requester: req0 held high with a0=15, b0=15, op0=1 for 4 operations -> 4 gnt0/done0 pairs spaced ALU_LAT+1 cycles apart, each with result=15; gnt1 never asserted.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Captures the winner's operands, waits ALU_LAT edges, then returns alu_out with a done pulse.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [1:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       win_q, win_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
  logic [7:0] result_q, result_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       pick;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = busy_q;
    result_d = result_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    // Contention resolves via the pointer; a lone requester always wins.
    pick     = (req0 && req1) ? ptr_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          alu_a_d  = pick ? a1  : a0;
          alu_b_d  = pick ? b1  : b0;
          alu_op_d = pick ? op1 : op0;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
          win_d    = pick;
          ptr_d    = ~pick;
          cnt_d    = LAT_INIT;
          busy_d   = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          result_d = alu_out;
          done0_d  = ~win_q;
          done1_d  = win_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and 3) against a transaction-level model
// that schedules grants/dones by cycle number.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req0_w, req1_w;
  logic [1:0][3:0] a0_w, b0_w, a1_w, b1_w;
  logic [1:0][1:0] op0_w, op1_w;
  logic [1:0]      gnt0_w, gnt1_w, done0_w, done1_w, busy_w;
  logic [1:0][7:0] result_w, alu_out_w;
  logic [1:0][3:0] alu_a_w, alu_b_w;
  logic [1:0][1:0] alu_op_w;

  alu_arbiter #(.ALU_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .req0(req0_w[0]), .a0(a0_w[0]), .b0(b0_w[0]), .op0(op0_w[0]),
    .req1(req1_w[0]), .a1(a1_w[0]), .b1(b1_w[0]), .op1(op1_w[0]),
    .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .done0(done0_w[0]), .done1(done1_w[0]),
    .result(result_w[0]), .busy(busy_w[0]),
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_op(alu_op_w[0]),
    .alu_out(alu_out_w[0])
  );

  alu_arbiter #(.ALU_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .req0(req0_w[1]), .a0(a0_w[1]), .b0(b0_w[1]), .op0(op0_w[1]),
    .req1(req1_w[1]), .a1(a1_w[1]), .b1(b1_w[1]), .op1(op1_w[1]),
    .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .done0(done0_w[1]), .done1(done1_w[1]),
    .result(result_w[1]), .busy(busy_w[1]),
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_op(alu_op_w[1]),
    .alu_out(alu_out_w[1])
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a | b);
      2'd2:    r = int'(a) - int'(b);
      default: r = int'(a ^ b);
    endcase
    return r[7:0];
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ALU models: total latency from arbiter grant edge to valid alu_out is ALU_LAT edges.
  logic [7:0] p1a, p1b;
  always @(posedge clk) begin
    p1a <= alu_fn(alu_a_w[1], alu_b_w[1], alu_op_w[1]);
    p1b <= p1a;
  end
  always_comb begin
    alu_out_w[0] = alu_fn(alu_a_w[0], alu_b_w[0], alu_op_w[0]);
    alu_out_w[1] = p1b;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operation scheduled as (grant cycle, done cycle, value).
  int         m_cyc = 0;
  bit         m_pend[2], m_ptr[2];
  int         m_done_at[2], m_nf[2];
  bit         m_who[2];
  logic [7:0] m_val[2];
  bit         e_gnt0[2], e_gnt1[2], e_done0[2], e_done1[2], e_busy[2];
  logic [7:0] e_result[2];
  logic [3:0] e_a[2], e_b[2];
  logic [1:0] e_op[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_ptr[k] = 0; m_nf[k] = 0; m_who[k] = 0;
      e_gnt0[k] = 0; e_gnt1[k] = 0; e_done0[k] = 0; e_done1[k] = 0; e_busy[k] = 0;
      e_result[k] = '0; e_a[k] = '0; e_b[k] = '0; e_op[k] = '0;
    end
  endtask

  task automatic model_edge();
    bit who;
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_gnt0[k] = 0; e_gnt1[k] = 0; e_done0[k] = 0; e_done1[k] = 0;
        if (m_pend[k] && m_cyc == m_done_at[k]) begin
          e_result[k] = m_val[k];
          if (m_who[k]) e_done1[k] = 1; else e_done0[k] = 1;
          m_pend[k] = 0;
        end
        if (!m_pend[k] && m_cyc >= m_nf[k] && (req0_w[k] || req1_w[k])) begin
          who = (req0_w[k] && req1_w[k]) ? m_ptr[k] : req1_w[k];
          e_a[k]  = who ? a1_w[k]  : a0_w[k];
          e_b[k]  = who ? b1_w[k]  : b0_w[k];
          e_op[k] = who ? op1_w[k] : op0_w[k];
          if (who) e_gnt1[k] = 1; else e_gnt0[k] = 1;
          m_who[k]     = who;
          m_ptr[k]     = !who;
          m_pend[k]    = 1;
          m_val[k]     = alu_fn(e_a[k], e_b[k], e_op[k]);
          m_done_at[k] = m_cyc + lat_of(k);
          m_nf[k]      = m_cyc + lat_of(k) + 1;
        end
        e_busy[k] = m_pend[k];
      end
    end
    m_cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("L%0d", lat_of(k));
      check({s, " gnt"},    32'({gnt1_w[k], gnt0_w[k]}),   32'({e_gnt1[k], e_gnt0[k]}));
      check({s, " done"},   32'({done1_w[k], done0_w[k]}), 32'({e_done1[k], e_done0[k]}));
      check({s, " busy"},   32'(busy_w[k]),                32'(e_busy[k]));
      check({s, " result"}, 32'(result_w[k]),              32'(e_result[k]));
      check({s, " alu_in"}, 32'({alu_a_w[k], alu_b_w[k], alu_op_w[k]}),
                            32'({e_a[k], e_b[k], e_op[k]}));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_both(input bit r0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [1:0] o0, input bit r1, input logic [3:0] a1,
                          input logic [3:0] b1, input logic [1:0] o1);
    for (int k = 0; k < 2; k++) begin
      req0_w[k] = r0; a0_w[k] = a0; b0_w[k] = b0; op0_w[k] = o0;
      req1_w[k] = r1; a1_w[k] = a1; b1_w[k] = b1; op1_w[k] = o1;
    end
  endtask

  // Requesters hold req/operands until granted; afterwards they may re-request or drop.
  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      if (req0_w[k]) begin
        if (e_gnt0[k]) begin
          req0_w[k] = 1'($urandom_range(1, 0));
          a0_w[k] = 4'($urandom); b0_w[k] = 4'($urandom); op0_w[k] = 2'($urandom);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        req0_w[k] = 1'b1;
        a0_w[k] = 4'($urandom); b0_w[k] = 4'($urandom); op0_w[k] = 2'($urandom);
      end
      if (req1_w[k]) begin
        if (e_gnt1[k]) begin
          req1_w[k] = 1'($urandom_range(1, 0));
          a1_w[k] = 4'($urandom); b1_w[k] = 4'($urandom); op1_w[k] = 2'($urandom);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        req1_w[k] = 1'b1;
        a1_w[k] = 4'($urandom); b1_w[k] = 4'($urandom); op1_w[k] = 2'($urandom);
      end
    end
  endtask

  initial begin
    set_both(1, 4'd5, 4'd5, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) step();
    rst = 1'b1;
    repeat (8) step();

    set_both(0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    repeat (4) step();
    set_both(1, 4'd9, 4'd8, 2'd0, 1, 4'd3, 4'd5, 2'd2);
    repeat (16) step();

    set_both(0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    repeat (4) step();
    set_both(0, 4'd0, 4'd0, 2'd0, 1, 4'd12, 4'd10, 2'd3);
    step();
    set_both(1, 4'd7, 4'd2, 2'd2, 0, 4'd12, 4'd10, 2'd3);
    repeat (8) step();

    set_both(0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    repeat (4) step();
    set_both(1, 4'd15, 4'd15, 2'd1, 0, 4'd0, 4'd0, 2'd0);
    repeat (16) step();

    // Mid-operation reset: asserted one cycle after a grant, req0 kept high.
    set_both(0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    repeat (4) step();
    set_both(1, 4'd6, 4'd3, 2'd0, 0, 4'd0, 4'd0, 2'd0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst = 1'b1;
    repeat (6) step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(149, 0) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat ($urandom_range(2, 1)) step();
        rst = 1'b1;
      end
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
